// File: rtl/axi_arb_lru.sv
// rtl/axi_arb_lru.sv - registered burst-locking arbiter with fixed, round-robin or LRU ranking
module axi_arb_lru #(
    parameter int SENDER_NUM = 8,
    parameter int MODE       = 2,
    parameter int IDX_W      = $clog2(SENDER_NUM)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SENDER_NUM-1:0]       req,
    input  logic                        hs,
    input  logic                        last,
    output logic [SENDER_NUM-1:0]       grant,
    output logic [IDX_W-1:0]            grant_idx,
    output logic                        grant_valid,
    output logic [SENDER_NUM*IDX_W-1:0] prio_rank
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                              state, state_d;
    logic [SENDER_NUM-1:0][IDX_W-1:0]    rank_q, rank_d;
    logic [SENDER_NUM-1:0]               grant_d;
    logic [IDX_W-1:0]                    idx_d;
    logic [SENDER_NUM-1:0]               arb_req;
    logic [IDX_W-1:0]                    win_idx;
    logic [IDX_W-1:0]                    best_rank;
    logic [IDX_W-1:0]                    old_r;
    logic                                win_any;
    logic                                done;
    int                                  rr_t;

    assign done        = (state == BUSY) && hs && last;
    assign grant_valid = (state == BUSY);
    assign prio_rank   = rank_q;

    always_comb begin
        rank_d = rank_q;
        old_r  = rank_q[grant_idx];
        rr_t   = 0;
        if (done) begin
            if (MODE == 1) begin
                // Sender k+1 becomes rank 0; kept within 0..N-1 without a modulo operator
                for (int i = 0; i < SENDER_NUM; i++) begin
                    rr_t = i + SENDER_NUM - 1 - int'(grant_idx);
                    if (rr_t >= SENDER_NUM) rr_t = rr_t - SENDER_NUM;
                    rank_d[i] = IDX_W'(rr_t);
                end
            end else if (MODE == 2) begin
                for (int i = 0; i < SENDER_NUM; i++) begin
                    if (IDX_W'(i) == grant_idx)
                        rank_d[i] = IDX_W'(SENDER_NUM - 1);
                    else if (rank_q[i] > old_r)
                        rank_d[i] = rank_q[i] - IDX_W'(1);
                end
            end
        end
    end

    // The completing sender is masked out so it cannot be re-granted back-to-back
    assign arb_req = (state == BUSY) ? (req & ~grant) : req;

    always_comb begin
        win_any   = 1'b0;
        win_idx   = '0;
        best_rank = '0;
        for (int i = 0; i < SENDER_NUM; i++) begin
            if (arb_req[i] && (!win_any || rank_d[i] < best_rank)) begin
                win_any   = 1'b1;
                win_idx   = IDX_W'(i);
                best_rank = rank_d[i];
            end
        end
    end

    always_comb begin
        state_d = state;
        grant_d = grant;
        idx_d   = grant_idx;
        case (state)
            IDLE: begin
                if (win_any) begin
                    state_d = BUSY;
                    grant_d = SENDER_NUM'(1) << win_idx;
                    idx_d   = win_idx;
                end
            end
            BUSY: begin
                if (done) begin
                    if (win_any) begin
                        grant_d = SENDER_NUM'(1) << win_idx;
                        idx_d   = win_idx;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            for (int i = 0; i < SENDER_NUM; i++) rank_q[i] <= IDX_W'(i);
        end else begin
            state     <= state_d;
            grant     <= grant_d;
            grant_idx <= idx_d;
            rank_q    <= rank_d;
        end
    end

endmodule

// File: tb/tb_axi_arb_lru.sv
// tb/tb_axi_arb_lru.sv - five arbiter configurations in lockstep against a priority-list model
module tb_axi_arb_lru;

    localparam int NC = 5;
    localparam int NN [NC] = '{8, 4, 4, 5, 5};
    localparam int MM [NC] = '{2, 2, 1, 0, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic       hs = 1'b0;
    logic       last = 1'b0;

    always #5 clk = ~clk;

    logic [7:0]  g0;  logic [2:0] i0;  logic v0;  logic [23:0] p0;
    logic [3:0]  g1;  logic [1:0] i1;  logic v1;  logic [7:0]  p1;
    logic [3:0]  g2;  logic [1:0] i2;  logic v2;  logic [7:0]  p2;
    logic [4:0]  g3;  logic [2:0] i3;  logic v3;  logic [14:0] p3;
    logic [4:0]  g4;  logic [2:0] i4;  logic v4;  logic [14:0] p4;

    axi_arb_lru #(.SENDER_NUM(8), .MODE(2)) u_dut (.clk(clk), .rst(rst), .req(req),
        .hs(hs), .last(last), .grant(g0), .grant_idx(i0), .grant_valid(v0), .prio_rank(p0));
    axi_arb_lru #(.SENDER_NUM(4), .MODE(2)) u_lru4 (.clk(clk), .rst(rst), .req(req[3:0]),
        .hs(hs), .last(last), .grant(g1), .grant_idx(i1), .grant_valid(v1), .prio_rank(p1));
    axi_arb_lru #(.SENDER_NUM(4), .MODE(1)) u_rr4 (.clk(clk), .rst(rst), .req(req[3:0]),
        .hs(hs), .last(last), .grant(g2), .grant_idx(i2), .grant_valid(v2), .prio_rank(p2));
    axi_arb_lru #(.SENDER_NUM(5), .MODE(0)) u_fix5 (.clk(clk), .rst(rst), .req(req[4:0]),
        .hs(hs), .last(last), .grant(g3), .grant_idx(i3), .grant_valid(v3), .prio_rank(p3));
    axi_arb_lru #(.SENDER_NUM(5), .MODE(1)) u_rr5 (.clk(clk), .rst(rst), .req(req[4:0]),
        .hs(hs), .last(last), .grant(g4), .grant_idx(i4), .grant_valid(v4), .prio_rank(p4));

    logic [7:0]  d_grant [NC];
    logic [2:0]  d_idx   [NC];
    logic        d_valid [NC];
    logic [23:0] d_rank  [NC];

    assign d_grant[0] = g0;          assign d_idx[0] = i0;          assign d_valid[0] = v0; assign d_rank[0] = p0;
    assign d_grant[1] = {4'b0, g1};  assign d_idx[1] = {1'b0, i1};  assign d_valid[1] = v1; assign d_rank[1] = {16'b0, p1};
    assign d_grant[2] = {4'b0, g2};  assign d_idx[2] = {1'b0, i2};  assign d_valid[2] = v2; assign d_rank[2] = {16'b0, p2};
    assign d_grant[3] = {3'b0, g3};  assign d_idx[3] = i3;          assign d_valid[3] = v3; assign d_rank[3] = {9'b0, p3};
    assign d_grant[4] = {3'b0, g4};  assign d_idx[4] = i4;          assign d_valid[4] = v4; assign d_rank[4] = {9'b0, p4};

    // Model: ord[c] lists senders from highest to lowest priority; rank = list position
    int ord  [NC][8];
    int gidx [NC];
    bit gv   [NC];
    bit chk_en = 1'b0;
    int n_checks = 0;
    int n_errs = 0;

    function automatic int rank_of(int c, int s);
        for (int j = 0; j < NN[c]; j++) if (ord[c][j] == s) return j;
        return 99;
    endfunction

    function automatic int pick(int c, logic [7:0] m);
        for (int j = 0; j < NN[c]; j++) if (m[ord[c][j]]) return ord[c][j];
        return 0;
    endfunction

    function automatic logic [7:0] exp_grant(int c);
        return gv[c] ? (8'(1) << gidx[c]) : 8'h00;
    endfunction

    function automatic logic [23:0] exp_rank(int c);
        logic [23:0] r;
        int w;
        r = '0;
        w = $clog2(NN[c]);
        for (int i = 0; i < NN[c]; i++) r = r | (24'(rank_of(c, i)) << (i * w));
        return r;
    endfunction

    always @(posedge clk) begin
        int n, k, p;
        logic [7:0] m;
        for (int c = 0; c < NC; c++) begin
            n = NN[c];
            m = req & 8'((1 << n) - 1);
            if (rst) begin
                for (int j = 0; j < 8; j++) ord[c][j] = j;
                gv[c] = 1'b0;
                gidx[c] = 0;
            end else if (!gv[c]) begin
                if (m != 0) begin
                    gidx[c] = pick(c, m);
                    gv[c] = 1'b1;
                end
            end else if (hs && last) begin
                k = gidx[c];
                if (MM[c] == 1) begin
                    for (int j = 0; j < n; j++) ord[c][j] = (k + 1 + j) % n;
                end else if (MM[c] == 2) begin
                    p = rank_of(c, k);
                    for (int j = p; j < n - 1; j++) ord[c][j] = ord[c][j + 1];
                    ord[c][n - 1] = k;
                end
                m[k] = 1'b0;
                if (m != 0) begin
                    gidx[c] = pick(c, m);
                end else begin
                    gv[c] = 1'b0;
                    gidx[c] = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s cfg%0d at %0t: got %0h expected %0h", name, c, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int c = 0; c < NC; c++) begin
                chk("grant", c, 32'(d_grant[c]), 32'(exp_grant(c)));
                chk("grant_idx", c, 32'(d_idx[c]), 32'(gidx[c]));
                chk("grant_valid", c, 32'(d_valid[c]), 32'(gv[c]));
                chk("prio_rank", c, 32'(d_rank[c]), 32'(exp_rank(c)));
            end
        end
    end

    task automatic lit_grant(input int c, input logic [7:0] exp);
        chk("lit_grant", c, 32'(d_grant[c]), 32'(exp));
        chk("lit_model_grant", c, 32'(exp_grant(c)), 32'(exp));
    endtask

    task automatic lit_rank(input int c, input logic [23:0] exp);
        chk("lit_rank", c, 32'(d_rank[c]), 32'(exp));
        chk("lit_model_rank", c, 32'(exp_rank(c)), 32'(exp));
    endtask

    task automatic cyc(input logic [7:0] r, input bit h, input bit l, input bit rs);
        req = r;
        hs = h;
        last = l;
        rst = rs;
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0] r;
        cyc(8'hff, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        cyc(8'hff, 1'b0, 1'b0, 1'b1);
        lit_grant(0, 8'h00);
        chk("lit_valid", 0, 32'(d_valid[0]), 32'd0);
        lit_rank(0, 24'o76543210);
        cyc(8'hff, 1'b0, 1'b0, 1'b0);
        lit_grant(0, 8'h01);

        do_reset();
        cyc(8'b0010, 1'b0, 1'b0, 1'b0);
        lit_grant(1, 8'b0010);
        for (int b = 0; b < 3; b++) begin
            cyc(8'b0011, 1'b1, 1'b0, 1'b0);
            lit_grant(1, 8'b0010);
        end
        cyc(8'b0011, 1'b1, 1'b1, 1'b0);
        lit_grant(1, 8'b0001);

        do_reset();
        cyc(8'b0100, 1'b0, 1'b0, 1'b0);
        lit_grant(1, 8'b0100);
        lit_grant(2, 8'b0100);
        cyc(8'b0001, 1'b1, 1'b1, 1'b0);
        lit_grant(1, 8'b0001);
        lit_rank(1, 24'b10110100);
        lit_rank(2, 24'b00111001);
        cyc(8'b1100, 1'b1, 1'b1, 1'b0);
        lit_grant(1, 8'b1000);
        lit_grant(2, 8'b0100);
        lit_rank(1, 24'b01100011);
        lit_rank(2, 24'b10010011);

        do_reset();
        cyc(8'b1111, 1'b0, 1'b0, 1'b0);
        lit_grant(1, 8'b0001);
        cyc(8'b1111, 1'b1, 1'b1, 1'b0);
        lit_grant(1, 8'b0010);
        lit_rank(1, 24'b10010011);
        cyc(8'b1111, 1'b1, 1'b1, 1'b0);
        lit_grant(1, 8'b0100);
        cyc(8'b1111, 1'b1, 1'b1, 1'b0);
        lit_grant(1, 8'b1000);
        cyc(8'b1111, 1'b1, 1'b1, 1'b0);
        lit_grant(1, 8'b0001);

        do_reset();
        cyc(8'b10100, 1'b0, 1'b0, 1'b0);
        lit_grant(3, 8'b00100);
        cyc(8'b10100, 1'b1, 1'b1, 1'b0);
        lit_grant(3, 8'b10000);
        cyc(8'b10100, 1'b1, 1'b1, 1'b0);
        lit_grant(3, 8'b00100);
        lit_rank(3, 24'o43210);

        do_reset();
        cyc(8'b10000, 1'b0, 1'b0, 1'b0);
        lit_grant(4, 8'b10000);
        cyc(8'b00000, 1'b1, 1'b1, 1'b0);
        lit_grant(4, 8'b00000);
        lit_rank(4, 24'o43210);

        do_reset();
        cyc(8'h04, 1'b0, 1'b0, 1'b0);
        lit_grant(0, 8'h04);
        cyc(8'h04, 1'b1, 1'b0, 1'b0);
        lit_grant(0, 8'h04);
        cyc(8'h04, 1'b1, 1'b1, 1'b1);
        lit_grant(0, 8'h00);
        lit_rank(0, 24'o76543210);

        for (int t = 0; t < 4000; t++) begin
            r = 8'($urandom);
            if ($urandom_range(3) == 0) r = r & 8'($urandom);
            if ($urandom_range(7) == 0) r = 8'h00;
            cyc(r, 1'($urandom_range(1)), $urandom_range(2) == 0, $urandom_range(149) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
